rgb_window3x3: RTL

RGB_WINDOW3X3 -- requirements
Module: rgb_window3x3

---
 rtl/rgb_window3x3.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/rgb_window3x3.sv
// 3x3 RGB neighbourhood generator: two line RAMs plus a three-column shift window.
// Borders are filled by replicating the nearest valid row or column; outputs lag the input by 3 clocks.
module rgb_window3x3 #(
    parameter int H_ACTIVE  = 480,
    parameter int RGB_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_hs,
    input  logic                     in_vs,
    input  logic                     in_de,
    input  logic [RGB_WIDTH-1:0]     in_data,
    output logic                     out_hs,
    output logic                     out_vs,
    output logic                     out_de,
    output logic [9*RGB_WIDTH-1:0]   out_win,
    output logic [9:0]               out_y
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int AW = $clog2(H_ACTIVE);
    localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);

    typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} state_t;
    typedef logic [2:0][RGB_WIDTH-1:0] column_t;

    state_t                state_r, state_next_s;
    logic                  de_prev_r, vs_prev_r;
    logic [XW-1:0]         x_r;
    logic [9:0]            y_r;
    logic                  de_fall_s, vs_rise_s, in_range_s, valid_s;
    logic [AW-1:0]         ram_idx_s;

    logic [RGB_WIDTH-1:0]  ram_a [H_ACTIVE];
    logic [RGB_WIDTH-1:0]  ram_b [H_ACTIVE];

    logic                  v1_r, v2_r;
    logic [XW-1:0]         x1_r, x2_r;
    logic [9:0]            y1_r, y2_r;
    logic [RGB_WIDTH-1:0]  p1_r, a1_r, b1_r;
    column_t               col1_s, col2_r, col3_r, left_s, right_s;
    logic [9*RGB_WIDTH-1:0] win_s;
    logic                  hs_p1_r, hs_p2_r, vs_p1_r, vs_p2_r;

    assign de_fall_s  = de_prev_r & ~in_de;
    assign vs_rise_s  = in_vs & ~vs_prev_r;
    assign in_range_s = (x_r < X_END);
    assign valid_s    = in_de & in_range_s & (state_r == ACTIVE);
    assign ram_idx_s  = in_range_s ? x_r[AW-1:0] : {AW{1'b0}};

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= WAIT_FRAME;
        else        state_r <= state_next_s;
    end

    // Next-state: leave WAIT_FRAME on the first in_vs rising edge, then stay
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WAIT_FRAME: begin
                if (vs_rise_s) state_next_s = ACTIVE;
                else           state_next_s = WAIT_FRAME;
            end
            ACTIVE:  state_next_s = ACTIVE;
            default: state_next_s = WAIT_FRAME;
        endcase
    end

    // Edge detectors and pixel/line counters; the vsync clear outranks the line increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_prev_r <= 1'b0;
            vs_prev_r <= 1'b0;
            x_r       <= {XW{1'b0}};
            y_r       <= 10'd0;
        end else begin
            de_prev_r <= in_de;
            vs_prev_r <= in_vs;
            if (de_fall_s)                  x_r <= {XW{1'b0}};
            else if (in_de && in_range_s)   x_r <= x_r + XW'(1);
            if (vs_rise_s)                         y_r <= 10'd0;
            else if (de_fall_s && y_r != 10'd1023) y_r <= y_r + 10'd1;
        end
    end

    // Line RAMs: A holds line y-1, B holds line y-2; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (valid_s) begin
            ram_b[ram_idx_s] <= ram_a[ram_idx_s];
            ram_a[ram_idx_s] <= in_data;
        end
    end

    // Stage 1: capture the incoming pixel and the two stored pixels above it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            x1_r <= {XW{1'b0}};
            y1_r <= 10'd0;
            p1_r <= {RGB_WIDTH{1'b0}};
            a1_r <= {RGB_WIDTH{1'b0}};
            b1_r <= {RGB_WIDTH{1'b0}};
        end else begin
            v1_r <= valid_s;
            x1_r <= x_r;
            y1_r <= y_r;
            p1_r <= in_data;
            a1_r <= ram_a[ram_idx_s];
            b1_r <= ram_b[ram_idx_s];
        end
    end

    // Vertical replication hides stale RAM data on the first two lines of a frame
    always_comb begin
        col1_s[2] = p1_r;
        if (y1_r == 10'd0) begin
            col1_s[1] = p1_r;
            col1_s[0] = p1_r;
        end else if (y1_r == 10'd1) begin
            col1_s[1] = a1_r;
            col1_s[0] = a1_r;
        end else begin
            col1_s[1] = a1_r;
            col1_s[0] = b1_r;
        end
    end

    // Stage 2/3: column shift register plus sync delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r    <= 1'b0;
            x2_r    <= {XW{1'b0}};
            y2_r    <= 10'd0;
            col2_r  <= '0;
            col3_r  <= '0;
            hs_p1_r <= 1'b0;
            hs_p2_r <= 1'b0;
            vs_p1_r <= 1'b0;
            vs_p2_r <= 1'b0;
        end else begin
            v2_r    <= v1_r;
            x2_r    <= x1_r;
            y2_r    <= y1_r;
            col2_r  <= col1_s;
            col3_r  <= col2_r;
            hs_p1_r <= in_hs;
            hs_p2_r <= hs_p1_r;
            vs_p1_r <= in_vs;
            vs_p2_r <= vs_p1_r;
        end
    end

    // Horizontal replication: right neighbour exists only if the next pixel is valid and not a new line
    always_comb begin
        if (x2_r == {XW{1'b0}}) left_s = col2_r;
        else                    left_s = col3_r;
        if (v1_r && (x1_r != {XW{1'b0}})) right_s = col1_s;
        else                              right_s = col2_r;
        win_s = '0;
        for (int r = 0; r < 3; r++) begin
            win_s[(r*3)*RGB_WIDTH   +: RGB_WIDTH] = left_s[r];
            win_s[(r*3+1)*RGB_WIDTH +: RGB_WIDTH] = col2_r[r];
            win_s[(r*3+2)*RGB_WIDTH +: RGB_WIDTH] = right_s[r];
        end
    end

    // Output registers; window is forced to zero outside valid pixels, out_y holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
            out_de  <= 1'b0;
            out_win <= '0;
            out_y   <= 10'd0;
        end else begin
            out_hs <= hs_p2_r;
            out_vs <= vs_p2_r;
            out_de <= v2_r;
            if (v2_r) begin
                out_win <= win_s;
                out_y   <= y2_r;
            end else begin
                out_win <= '0;
                out_y   <= out_y;
            end
        end
    end

endmodule
